// File: rtl/ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_arbiter_pkg
// Shared definitions for the two-port RAM arbiter:
//   - controller state encoding (INIT sweep, RUN arbitration)
//   - default address/data widths and the value written by the init sweep
// ---------------------------------------------------------------------------
package ram_arbiter_pkg;

  // Controller states: INIT clears every RAM word, RUN serves requesters.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Port identifiers as stored in the round-robin "last granted" register.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Default geometry of the attached RAM and the power-up clear value.
  localparam int          AW_DEF       = 4;
  localparam int          DW_DEF       = 8;
  localparam logic [7:0]  INIT_VAL_DEF = 8'h00;

endpackage : ram_arbiter_pkg

// File: rtl/ram_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Purely combinational two-way round-robin picker. The "last granted"
// history is owned by the caller, which keeps this block stateless.
//
// Ports:
//   req0, req1  in   requests from port 0 / port 1
//   last        in   port granted most recently (0 or 1)
//   gnt0, gnt1  out  one-hot (or zero) grant
// ---------------------------------------------------------------------------
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // it unassigned; an unassigned path in always_comb infers a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      // Contention: the port that did not win last time goes first.
      gnt0 = (last == PORT1);
      gnt1 = (last == PORT0);
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule : rr_arb2

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Owns one single-port synchronous-read RAM and shares it between two
// independent requesters. After reset every word is cleared to INIT_VAL
// (one word per clock), then at most one read or write per clock is granted
// round-robin to port 0 or port 1. Read data returns one cycle after grant.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req*/we*/addr*/wdata* per-port request, 1 = write / 0 = read, address, data
//   gnt0, gnt1            combinational grant; request consumed at this edge
//   rvalid0, rvalid1      registered; shared rdata belongs to this port now
//   rdata                 pass-through of ram_rdata
//   init_done             registered; high once the clear sweep is complete
//   ram_we/addr/wdata     RAM command outputs
//   ram_rdata             RAM registered read data (valid cycle after address)
// ---------------------------------------------------------------------------
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int          AW       = AW_DEF,
  parameter int          DW       = DW_DEF,
  parameter logic [DW-1:0] INIT_VAL = INIT_VAL_DEF
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,

  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,

  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          init_done,

  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  state_e        state_q,     state_d;
  logic [AW-1:0] init_cnt_q,  init_cnt_d;
  logic          last_q,      last_d;
  logic          init_done_q, init_done_d;
  logic          rvalid0_q,   rvalid0_d;
  logic          rvalid1_q,   rvalid1_d;

  logic          arb_gnt0;
  logic          arb_gnt1;

  rr_arb2 u_arb (
    .req0 (req0),
    .req1 (req1),
    .last (last_q),
    .gnt0 (arb_gnt0),
    .gnt1 (arb_gnt1)
  );

  // -------------------------------------------------------------------------
  // Next-state and RAM command logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    last_d      = last_q;
    init_done_d = init_done_q;

    gnt0        = 1'b0;
    gnt1        = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;

    unique case (state_q)
      ST_INIT: begin
        // Clear sweep: one word per clock; requests are ignored, not queued.
        ram_we     = 1'b1;
        ram_addr   = init_cnt_q;
        ram_wdata  = INIT_VAL;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end

      ST_RUN: begin
        gnt0 = arb_gnt0;
        gnt1 = arb_gnt1;
        if (arb_gnt0) begin
          ram_we    = we0;
          ram_addr  = addr0;
          ram_wdata = wdata0;
          last_d    = PORT0;
        end else if (arb_gnt1) begin
          ram_we    = we1;
          ram_addr  = addr1;
          ram_wdata = wdata1;
          last_d    = PORT1;
        end
      end
    endcase

    // A granted read owns the shared rdata bus in the following cycle.
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      last_q      <= PORT1;   // port 0 wins the first contention
      init_done_q <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      last_q      <= last_d;
      init_done_q <= init_done_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
    end
  end

  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign init_done = init_done_q;
  assign rdata     = ram_rdata;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Self-checking bench for ram_arbiter with an attached 16x8 synchronous-read
// RAM. A transaction-level reference model (cycle count since reset, a word
// array, the last-winner port) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, init_done;
  logic [DW-1:0] rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW), .INIT_VAL(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .init_done (init_done),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // 16x8 synchronous-read RAM (read returns the pre-write contents).
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we === 1'b1) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  int            checks = 0;
  int            errors = 0;
  bit            m_valid = 1'b0;  // model known only after the first reset edge
  int            m_cycle;         // clocks spent clearing since reset
  int            m_last;          // port that won most recently
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_rv0, m_rv1;
  logic [DW-1:0] m_rdata;
  bit            m_g0, m_g1;      // grants predicted for the cycle just ended
  bit            p0, p1;          // random requesters: transaction pending
  int            cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already driven: checks this cycle's
  // outputs against the model, advances the model across the edge, and
  // returns at the next posedge+1.
  task automatic tick();
    bit            clearing;
    int            winner;
    bit            eg0, eg1, ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    #1;
    clearing = (m_cycle < DEPTH);
    eg0 = 1'b0; eg1 = 1'b0; ewe = 1'b0; eaddr = '0; ewd = '0;
    if (clearing) begin
      ewe   = 1'b1;
      eaddr = AW'(m_cycle);
      ewd   = 8'h00;
    end else if (req0 || req1) begin
      if (req0 && req1) winner = 1 - m_last;
      else              winner = req0 ? 0 : 1;
      eg0 = (winner == 0);
      eg1 = (winner == 1);
      ewe   = eg0 ? we0    : we1;
      eaddr = eg0 ? addr0  : addr1;
      ewd   = eg0 ? wdata0 : wdata1;
    end

    if (m_valid) begin
      check("gnt0",      32'(gnt0),      32'(eg0));
      check("gnt1",      32'(gnt1),      32'(eg1));
      check("ram_we",    32'(ram_we),    32'(ewe));
      check("ram_addr",  32'(ram_addr),  32'(eaddr));
      check("ram_wdata", 32'(ram_wdata), 32'(ewd));
      check("init_done", 32'(init_done), 32'(!clearing));
      check("rvalid0",   32'(rvalid0),   32'(m_rv0));
      check("rvalid1",   32'(rvalid1),   32'(m_rv1));
      if (m_rv0 || m_rv1) check("rdata", 32'(rdata), 32'(m_rdata));
      check("gnt_onehot", 32'(gnt0 & gnt1), 32'(0));

      m_rdata = m_mem[eaddr];
      if (ewe) m_mem[eaddr] = ewd;
    end

    if (rst) begin
      m_valid = 1'b1;
      m_cycle = 0;
      m_last  = 1;
      m_rv0   = 1'b0;
      m_rv1   = 1'b0;
    end else if (m_valid) begin
      if (clearing) m_cycle++;
      m_rv0 = eg0 && !we0;
      m_rv1 = eg1 && !we1;
      if (eg0) m_last = 0;
      if (eg1) m_last = 1;
    end
    m_g0 = eg0;
    m_g1 = eg1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd5; wdata1 = '0;   // req1 held from reset
    @(posedge clk);
    #1;

    // ---- Reset, then the clear sweep --------------------------------------
    tick();
    check("rst_init_done", 32'(init_done), 32'(0));
    check("rst_rvalid0",   32'(rvalid0),   32'(0));
    check("rst_rvalid1",   32'(rvalid1),   32'(0));
    #1;
    check("rst_ram_we",    32'(ram_we),    32'(1));
    check("rst_ram_addr",  32'(ram_addr),  32'(0));
    check("rst_gnt1",      32'(gnt1),      32'(0));
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) tick();
    check("init_done_c16", 32'(init_done), 32'(1));
    #1;
    check("first_run_gnt1", 32'(gnt1), 32'(1));
    tick();
    req1 = 1'b0;
    check("post_init_rv1",    32'(rvalid1), 32'(1));
    check("post_init_rdata",  32'(rdata),   32'(8'h00));

    // ---- Port 0 writes A5 @3, port 1 reads it back next cycle --------------
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 8'hA5;
    tick();
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3;
    check("wr_no_rvalid0", 32'(rvalid0), 32'(0));
    tick();
    req1 = 1'b0;
    check("rbw_rvalid1", 32'(rvalid1), 32'(1));
    check("rbw_rdata",   32'(rdata),   32'(8'hA5));
    check("rbw_rvalid0", 32'(rvalid0), 32'(0));

    // ---- Seed distinct values at addresses 1 and 2 --------------------------
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd1; wdata0 = 8'h11;
    tick();
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd2; wdata1 = 8'h22;
    tick();

    // ---- Continuous contention: port 1 won last, so 0,1,0,1,... -------------
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        check("cont_rvalid0", 32'(rvalid0), 32'((i - 1) % 2 == 0));
        check("cont_rvalid1", 32'(rvalid1), 32'((i - 1) % 2 == 1));
        check("cont_rdata",   32'(rdata),   ((i - 1) % 2 == 0) ? 32'h11 : 32'h22);
      end
      #1;
      check("cont_gnt0", 32'(gnt0), 32'(i % 2 == 0));
      check("cont_gnt1", 32'(gnt1), 32'(i % 2 == 1));
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    check("cont_last_rv1",   32'(rvalid1), 32'(1));
    check("cont_last_rdata", 32'(rdata),   32'h22);

    // ---- Read granted in N, reset in N+1 ------------------------------------
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd2;
    tick();
    req0 = 1'b0;
    rst  = 1'b1;
    check("rd_rst_rvalid0_n1", 32'(rvalid0), 32'(1));
    tick();
    rst = 1'b0;
    check("rd_rst_rvalid0_n2", 32'(rvalid0),   32'(0));
    check("rd_rst_init_done",  32'(init_done), 32'(0));
    #1;
    check("rd_rst_ram_we",     32'(ram_we),    32'(1));
    check("rd_rst_ram_addr",   32'(ram_addr),  32'(0));

    // ---- Reset at init cycle 7 restarts a full 16-cycle sweep ---------------
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    while (init_done !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("reinit_len", 32'(cnt), 32'(16));

    // ---- Randomised traffic with well-behaved requesters ---------------------
    p0 = 1'b0;
    p1 = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!p0 && $urandom_range(0, 99) < 60) begin
        p0 = 1'b1;
        we0 = 1'($urandom_range(0, 1));
        addr0 = AW'($urandom_range(0, DEPTH - 1));
        wdata0 = DW'($urandom);
      end
      if (!p1 && $urandom_range(0, 99) < 60) begin
        p1 = 1'b1;
        we1 = 1'($urandom_range(0, 1));
        addr1 = AW'($urandom_range(0, DEPTH - 1));
        wdata1 = DW'($urandom);
      end
      req0 = p0;
      req1 = p1;
      tick();
      if (m_g0) p0 = 1'b0;
      if (m_g1) p1 = 1'b0;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ram_arbiter
